// File: rtl/regfile_wport_arbiter_if.sv
// Bundle of the write-port arbiter's requester, ID and regfile signals.
// The slave modport is the arbiter's view; the master modport drives it.
interface regfile_wport_arbiter_if;
  logic        wb_we_i;
  logic [4:0]  wb_waddr_i;
  logic [31:0] wb_wdata_i;
  logic        lu_valid_i;
  logic        lu_ready_o;
  logic [4:0]  lu_waddr_i;
  logic [31:0] lu_wdata_i;
  logic        rsv_i;
  logic [4:0]  rsv_addr_i;
  logic        re1_i;
  logic        re2_i;
  logic [4:0]  raddr1_i;
  logic [4:0]  raddr2_i;
  logic        rd_stall_o;
  logic        stall_req_o;
  logic        we_o;
  logic [4:0]  waddr_o;
  logic [31:0] wdata_o;

  modport slave (
    input  wb_we_i, wb_waddr_i, wb_wdata_i,
    input  lu_valid_i, lu_waddr_i, lu_wdata_i,
    output lu_ready_o,
    input  rsv_i, rsv_addr_i, re1_i, re2_i, raddr1_i, raddr2_i,
    output rd_stall_o, stall_req_o, we_o, waddr_o, wdata_o
  );

  modport master (
    output wb_we_i, wb_waddr_i, wb_wdata_i,
    output lu_valid_i, lu_waddr_i, lu_wdata_i,
    input  lu_ready_o,
    output rsv_i, rsv_addr_i, re1_i, re2_i, raddr1_i, raddr2_i,
    input  rd_stall_o, stall_req_o, we_o, waddr_o, wdata_o
  );
endinterface

// File: rtl/regfile_wport_arbiter.sv
// Shares the regfile write port between WB (priority) and a buffered
// long-latency unit, with a busy-register scoreboard and starvation relief.
module regfile_wport_arbiter #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                     clk,
  input logic                     rst,
  regfile_wport_arbiter_if.slave  bus
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PEND  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;

  logic [4:0]    fifo_addr_q [FIFO_DEPTH];
  logic [31:0]   fifo_data_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic [31:0]   busy_q, busy_d;
  logic [1:0]    state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          stall_req_q, stall_req_d;

  logic          full, empty, lu_ready, push, commit, port_active;
  logic [4:0]    head_addr, sel_addr;
  logic [31:0]   head_data, sel_data;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign lu_ready  = !rst && !full;
  assign push      = bus.lu_valid_i && lu_ready;
  assign head_addr = fifo_addr_q[rd_ptr_q];
  assign head_data = fifo_data_q[rd_ptr_q];

  // WB always wins; the FIFO head only commits on cycles WB leaves free.
  assign commit      = !bus.wb_we_i && !empty;
  assign sel_addr    = bus.wb_we_i ? bus.wb_waddr_i : head_addr;
  assign sel_data    = bus.wb_we_i ? bus.wb_wdata_i : head_data;
  assign port_active = !rst && (bus.wb_we_i || !empty);

  assign bus.lu_ready_o  = lu_ready;
  assign bus.we_o        = port_active && (sel_addr != 5'd0);
  assign bus.waddr_o     = port_active ? sel_addr : 5'd0;
  assign bus.wdata_o     = port_active ? sel_data : 32'd0;
  assign bus.stall_req_o = stall_req_q;
  assign bus.rd_stall_o  = (bus.re1_i && (bus.raddr1_i != 5'd0) && busy_q[bus.raddr1_i]) ||
                           (bus.re2_i && (bus.raddr2_i != 5'd0) && busy_q[bus.raddr2_i]);

  assign count_d = count_q + CW'(push) - CW'(commit);

  // Clear precedes set so a same-cycle reservation of the committing register survives.
  always_comb begin
    busy_d = busy_q;
    if (commit) begin
      busy_d[head_addr] = 1'b0;
    end
    if (bus.rsv_i && (bus.rsv_addr_i != 5'd0)) begin
      busy_d[bus.rsv_addr_i] = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    case (state_q)
      ST_IDLE: begin
        starve_d = '0;
        if (count_d != '0) begin
          state_d = ST_PEND;
        end
      end
      ST_PEND: begin
        if (commit) begin
          starve_d = '0;
        end else if (bus.wb_we_i && !empty) begin
          starve_d = starve_q + SW'(1);
        end
        if (count_d == '0) begin
          state_d  = ST_IDLE;
          starve_d = '0;
        end else if (starve_d == SW'(STARVE_LIMIT)) begin
          state_d = ST_FORCE;
        end
      end
      ST_FORCE: begin
        if (commit) begin
          starve_d = '0;
          state_d  = (count_d != '0) ? ST_PEND : ST_IDLE;
        end
      end
      default: begin
        state_d  = ST_IDLE;
        starve_d = '0;
      end
    endcase
  end

  assign stall_req_d = (state_d == ST_FORCE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      busy_q      <= '0;
      state_q     <= ST_IDLE;
      starve_q    <= '0;
      stall_req_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (commit) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q     <= count_d;
      busy_q      <= busy_d;
      state_q     <= state_d;
      starve_q    <= starve_d;
      stall_req_q <= stall_req_d;
    end
  end

  // Result storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.lu_waddr_i;
      fifo_data_q[wr_ptr_q] <= bus.lu_wdata_i;
    end
  end

endmodule

// File: tb/tb_regfile_wport_arbiter.sv
// Directed bench: stimulus queues expected regfile writes, a negedge monitor
// pops and compares every write the arbiter presents.
module tb_regfile_wport_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  regfile_wport_arbiter_if bus ();

  regfile_wport_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  int  total  = 0;
  int  passed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    wr_t e;
    e.a = a;
    e.d = d;
    exp_q.push_back(e);
  endtask

  task automatic clr();
    bus.wb_we_i = 1'b0; bus.wb_waddr_i = '0; bus.wb_wdata_i = '0;
    bus.lu_valid_i = 1'b0; bus.lu_waddr_i = '0; bus.lu_wdata_i = '0;
    bus.rsv_i = 1'b0; bus.rsv_addr_i = '0;
    bus.re1_i = 1'b0; bus.re2_i = 1'b0; bus.raddr1_i = '0; bus.raddr2_i = '0;
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    bus.wb_we_i = 1'b1; bus.wb_waddr_i = a; bus.wb_wdata_i = d;
  endtask

  task automatic lu(input logic [4:0] a, input logic [31:0] d);
    bus.lu_valid_i = 1'b1; bus.lu_waddr_i = a; bus.lu_wdata_i = d;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_we"},        32'(bus.we_o), 32'd0);
    chk({tag, "_waddr"},     32'(bus.waddr_o), 32'd0);
    chk({tag, "_wdata"},     bus.wdata_o, 32'd0);
    chk({tag, "_lu_ready"},  32'(bus.lu_ready_o), 32'd0);
    chk({tag, "_stall_req"}, 32'(bus.stall_req_o), 32'd0);
    chk({tag, "_rd_stall"},  32'(bus.rd_stall_o), 32'd0);
  endtask

  // Monitor: every regfile write must match the oldest queued expectation.
  always @(negedge clk) begin : monitor
    wr_t e;
    if (bus.we_o === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        $display("FAIL unexpected_write: got $%0d <= 0x%08h, required no write",
                 bus.waddr_o, bus.wdata_o);
      end else begin
        e = exp_q.pop_front();
        $display("write $%0d <= 0x%08h (expected $%0d <= 0x%08h)",
                 bus.waddr_o, bus.wdata_o, e.a, e.d);
        chk("write_addr", 32'(bus.waddr_o), 32'(e.a));
        chk("write_data", bus.wdata_o, e.d);
      end
    end
  end

  initial begin
    clr();
    #2;
    chk_all_zero("reset_init");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    settle();
    chk("ready_after_reset", 32'(bus.lu_ready_o), 32'd1);

    // Single long-latency result to $7
    step(); bus.rsv_i = 1'b1; bus.rsv_addr_i = 5'd7; bus.re1_i = 1'b1; bus.raddr1_i = 5'd7;
    settle(); chk("single_rd_stall_c0", 32'(bus.rd_stall_o), 32'd0);
    step(); bus.rsv_i = 1'b0;
    settle(); chk("single_rd_stall_c1", 32'(bus.rd_stall_o), 32'd1);
    step();
    settle(); chk("single_rd_stall_c2", 32'(bus.rd_stall_o), 32'd1);
    step(); lu(5'd7, 32'hDEADBEEF);
    settle(); chk("single_lu_ready", 32'(bus.lu_ready_o), 32'd1);
    chk("single_rd_stall_c3", 32'(bus.rd_stall_o), 32'd1);
    step(); bus.lu_valid_i = 1'b0; expect_wr(5'd7, 32'hDEADBEEF);
    settle(); chk("single_rd_stall_c4", 32'(bus.rd_stall_o), 32'd1);
    step();
    settle(); chk("single_rd_stall_c5", 32'(bus.rd_stall_o), 32'd0);
    bus.re1_i = 1'b0;

    // Full FIFO under continuous WB traffic
    step(); wb(5'd1, 32'h100); lu(5'd10, 32'hA0); expect_wr(5'd1, 32'h100);
    step(); wb(5'd2, 32'h101); lu(5'd11, 32'hA1); expect_wr(5'd2, 32'h101);
    settle(); chk("full_ready_c1", 32'(bus.lu_ready_o), 32'd1);
    step(); wb(5'd3, 32'h102); lu(5'd12, 32'hA2); expect_wr(5'd3, 32'h102);
    settle(); chk("full_ready_c2", 32'(bus.lu_ready_o), 32'd0);
    step(); wb(5'd4, 32'h103); expect_wr(5'd4, 32'h103);
    settle(); chk("full_ready_c3", 32'(bus.lu_ready_o), 32'd0);
    chk("full_no_stall", 32'(bus.stall_req_o), 32'd0);
    step(); bus.wb_we_i = 1'b0; expect_wr(5'd10, 32'hA0);
    settle(); chk("full_ready_c4", 32'(bus.lu_ready_o), 32'd0);
    step(); expect_wr(5'd11, 32'hA1);
    settle(); chk("full_ready_c5", 32'(bus.lu_ready_o), 32'd1);
    step(); bus.lu_valid_i = 1'b0; expect_wr(5'd12, 32'hA2);
    step();

    // Starvation relief
    step(); lu(5'd13, 32'h5000_0013);
    step(); bus.lu_valid_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wb(5'(20 + i), 32'h7700 + 32'(i));
      expect_wr(5'(20 + i), 32'h7700 + 32'(i));
      settle();
      chk("starve_no_stall_yet", 32'(bus.stall_req_o), 32'd0);
      step();
    end
    bus.wb_we_i = 1'b0; expect_wr(5'd13, 32'h5000_0013);
    settle(); chk("starve_stall_req", 32'(bus.stall_req_o), 32'd1);
    step();
    settle(); chk("starve_stall_released", 32'(bus.stall_req_o), 32'd0);

    // Reservation and commit to the same register; push+pop with one entry
    step(); bus.rsv_i = 1'b1; bus.rsv_addr_i = 5'd9;
    step(); bus.rsv_i = 1'b0; lu(5'd9, 32'h99);
    step(); bus.lu_valid_i = 1'b0; bus.rsv_i = 1'b1; bus.rsv_addr_i = 5'd9;
    expect_wr(5'd9, 32'h99);
    step(); bus.rsv_i = 1'b0; bus.re1_i = 1'b1; bus.raddr1_i = 5'd9; lu(5'd14, 32'hE0);
    settle(); chk("same_cycle_set_wins_r1", 32'(bus.rd_stall_o), 32'd1);
    step(); bus.re1_i = 1'b0; bus.re2_i = 1'b1; bus.raddr2_i = 5'd9; lu(5'd15, 32'hE1);
    expect_wr(5'd14, 32'hE0);
    settle(); chk("same_cycle_set_wins_r2", 32'(bus.rd_stall_o), 32'd1);
    step(); bus.lu_valid_i = 1'b0; bus.re2_i = 1'b0; expect_wr(5'd15, 32'hE1);
    settle(); chk("push_pop_occupancy_one", 32'(bus.lu_ready_o), 32'd1);
    step();

    // Register $0 handling
    step(); bus.rsv_i = 1'b1; bus.rsv_addr_i = 5'd0; lu(5'd0, 32'h12);
    step(); bus.rsv_i = 1'b0; bus.lu_valid_i = 1'b0;
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd0; bus.re2_i = 1'b1; bus.raddr2_i = 5'd0;
    settle(); chk("zero_lu_no_we", 32'(bus.we_o), 32'd0);
    chk("zero_rsv_no_rd_stall", 32'(bus.rd_stall_o), 32'd0);
    step(); bus.re1_i = 1'b0; bus.re2_i = 1'b0; wb(5'd0, 32'h55); lu(5'd16, 32'h1600);
    settle(); chk("zero_wb_no_we", 32'(bus.we_o), 32'd0);
    step(); bus.wb_we_i = 1'b0; bus.lu_valid_i = 1'b0; expect_wr(5'd16, 32'h1600);
    step();

    // Reset mid-traffic with two buffered results and busy registers
    step(); bus.rsv_i = 1'b1; bus.rsv_addr_i = 5'd5; wb(5'd1, 32'h200); lu(5'd17, 32'h1700);
    expect_wr(5'd1, 32'h200);
    step(); bus.rsv_i = 1'b0; wb(5'd2, 32'h201); lu(5'd18, 32'h1800);
    expect_wr(5'd2, 32'h201);
    step(); bus.lu_valid_i = 1'b0; wb(5'd3, 32'h202);
    bus.re1_i = 1'b1; bus.raddr1_i = 5'd5; bus.re2_i = 1'b1; bus.raddr2_i = 5'd9;
    rst = 1'b1;
    #1;
    chk_all_zero("reset_mid");
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.wb_we_i = 1'b0;
    settle();
    chk("reset_release_ready", 32'(bus.lu_ready_o), 32'd1);
    chk("reset_busy_cleared", 32'(bus.rd_stall_o), 32'd0);
    step();
    step();
    settle();
    chk("reset_fifo_empty_ready", 32'(bus.lu_ready_o), 32'd1);
    clr();
    step();

    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
